// File: rtl/mips_mem_pkg.sv
// Shared definitions for the memory stage: access sizes, FSM states and the
// writeback select code under which memdata is consumed.
package mips_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] REGSEL_MEMDATA = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } mem_state_e;

    // Reserved size 2'b11 behaves as a word access.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        if (size == SZ_BYTE) return 1'b1;
        if (size == SZ_HALF) return ~off[0];
        return off == 2'b00;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory req/ack port between the load/store unit (master) and memory.
interface mem_access_if #(
    parameter int ADDR_W = 32
);
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_be;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_rdata, dm_ack
    );
endinterface

// File: rtl/mem_access_load_align.sv
// Big-endian lane extraction of a loaded word followed by sign/zero extension.
module load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // Offset 0 is the most significant byte of the word.
        case (off_i)
            2'd0:    byte_lane = rdata_i[31:24];
            2'd1:    byte_lane = rdata_i[23:16];
            2'd2:    byte_lane = rdata_i[15:8];
            default: byte_lane = rdata_i[7:0];
        endcase
        half_lane = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];

        case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
            SZ_HALF: data_o = {{16{signed_i & half_lane[15]}}, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage load/store unit: req/ack data port, big-endian lane steering,
// load extension and pipeline stall. MEM_TIMEOUT_EN adds an ack timeout (bus_err).
module mem_access
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [1:0]        ex_size,
    input  logic              ex_signed,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    output logic              stall,
    mem_access_if.master      dm,
    output logic [31:0]       memdata,
    output logic              mem_valid,
    output logic              misalign_exc,
    output logic              bus_err
);

    mem_state_e        state_q;
    logic              load_q;
    logic              signed_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       memdata_q;
    logic              mem_valid_q;
    logic              misalign_q;
    logic              bus_err_q;

    logic              op_d;
    logic              aligned_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [31:0]       load_data_d;

    assign op_d      = ex_valid & (ex_load | ex_store);
    assign aligned_d = is_aligned(ex_size, ex_addr[1:0]);

    always_comb begin
        case (ex_size)
            SZ_BYTE: begin
                be_d    = 4'b1000 >> ex_addr[1:0];
                wdata_d = {4{ex_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_d    = ex_addr[1] ? 4'b0011 : 4'b1100;
                wdata_d = {2{ex_wdata[15:0]}};
            end
            default: begin
                be_d    = '1;
                wdata_d = ex_wdata;
            end
        endcase
        if (ex_load) be_d = '1;
    end

    load_align u_load_align (
        .rdata_i  (dm.dm_rdata),
        .off_i    (off_q),
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_o   (load_data_d)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            load_q      <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= '0;
            off_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            memdata_q   <= '0;
            mem_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            mem_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (op_d) begin
                        if (!aligned_d) begin
                            misalign_q <= 1'b1;
                        end else begin
                            state_q  <= ST_REQ;
                            req_q    <= 1'b1;
                            we_q     <= ~ex_load;
                            addr_q   <= {ex_addr[ADDR_W-1:2], 2'b00};
                            be_q     <= be_d;
                            wdata_q  <= wdata_d;
                            load_q   <= ex_load;
                            signed_q <= ex_signed;
                            size_q   <= ex_size;
                            off_q    <= ex_addr[1:0];
`ifdef MEM_TIMEOUT_EN
                            tmo_q    <= '0;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    // mem_valid is raised here so it is visible during DONE.
                    if (dm.dm_ack) begin
                        state_q <= ST_DONE;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= '0;
                        if (load_q) begin
                            memdata_q   <= load_data_d;
                            mem_valid_q <= 1'b1;
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        state_q   <= ST_IDLE;
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        be_q      <= '0;
                        bus_err_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign stall = ((state_q == ST_IDLE) && op_d && aligned_d) ||
                   ((state_q == ST_REQ) && !dm.dm_ack);

    assign dm.dm_req    = req_q;
    assign dm.dm_we     = we_q;
    assign dm.dm_addr   = addr_q;
    assign dm.dm_be     = be_q;
    assign dm.dm_wdata  = wdata_q;
    assign memdata      = memdata_q;
    assign mem_valid    = mem_valid_q;
    assign misalign_exc = misalign_q;
    assign bus_err      = bus_err_q;

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
Memory-stage load/store unit. It is the producer of the `memdata` operand consumed by the writeback select, with `regsel` = 3'b011.
- Accepts one load/store per transaction from the execute stage.
- Drives a req/ack data-memory port and performs big-endian byte-lane steering and sign/zero extension.
- Stalls the pipeline until the access completes.

Parameters:
- ADDR_W, 32, byte-address width.
- TIMEOUT_CYCLES, 16, max cycles waiting for dm_ack; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- ex_valid  in  1  execute-stage op valid
- ex_load  in  1  op is a load
- ex_store  in  1  op is a store (ex_load and ex_store both high: treated as load)
- ex_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- ex_signed  in  1  sign-extend loaded byte/half
- ex_addr  in  ADDR_W  byte address
- ex_wdata  in  32  store data, right-aligned
- stall  out  1  hold upstream pipeline
- dm_req  out  1  memory request
- dm_we  out  1  write enable
- dm_addr  out  ADDR_W  word-aligned address, low 2 bits zero
- dm_be  out  4  byte enables; bit3 = bits 31:24
- dm_wdata  out  32  lane-replicated store data
- dm_rdata  in  32  read data, valid with dm_ack
- dm_ack  in  1  completes request
- memdata  out  32  extended load result to writeback
- mem_valid  out  1  one-cycle pulse: memdata updated
- misalign_exc  out  1  one-cycle pulse: misaligned access dropped
- bus_err  out  1  one-cycle pulse: timeout (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - State returns to IDLE.
  - dm_req, dm_we, dm_be, mem_valid, misalign_exc and bus_err are 0.
  - dm_addr, dm_wdata and memdata are 0.
  - Reset mid-transaction abandons the request.
  - A dm_ack arriving while in IDLE is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE, with ex_valid and (ex_load or ex_store):
  - Alignment check: half requires addr[0]=0; word requires addr[1:0]=00.
  - Misaligned: misalign_exc=1 next cycle; no request; memdata unchanged; stay IDLE.
  - Aligned: capture op, size, signed, addr[1:0] and lanes; move to REQ. dm_req=1 from the next cycle.
- IDLE, with ex_valid and no load/store: no action.
- REQ:
  - dm_req held at 1; dm_addr, dm_we, dm_be and dm_wdata held stable until dm_ack.
  - On dm_ack: for loads, extract the lane from dm_rdata into memdata; dm_req=0; go to DONE.
- DONE: mem_valid=1 for one cycle only for loads; stores produce no mem_valid; go to IDLE.
- stall = 1 while (IDLE and accepting an aligned op) or in REQ. It drops in the cycle dm_ack is seen.
- Latency:
  - Minimum load, ack same cycle as first req: accept at cycle 0, req at cycle 1, mem_valid at cycle 2.
  - Back-to-back ops: the next op is accepted in DONE's following IDLE cycle.
- Lanes, big-endian:
  - Byte: be = 4'b1000 >> addr[1:0]; wdata = {4{b}}.
  - Half: be = addr[1] ? 0011 : 1100; wdata = {2{h}}.
  - Word: be = 1111.
  - Loads always request with be = 1111.
- Extension: byte/half zero-extended when ex_signed=0; otherwise sign-extended from bit 7/15.

Optional Feature:
MEM_TIMEOUT_EN.
- Defined: a counter starts on entering REQ. If TIMEOUT_CYCLES cycles pass without dm_ack:
  - dm_req drops; bus_err pulses 1 cycle; return to IDLE with no mem_valid.
  - A late dm_ack is ignored.
- Undefined: no counter; REQ waits indefinitely; bus_err is constant 0.

Decomposition:
- Shared package mips_mem_pkg holds:
  - size encodings (SZ_BYTE/SZ_HALF/SZ_WORD);
  - FSM state typedef;
  - the writeback regsel constant for memdata (3'b011).
- One sub-module, load_align: pure combinational lane extract and sign/zero extension from {rdata, addr[1:0], size, signed}. The store-lane generator stays inline.

Test Plan:
- Signed byte load, addr 0x1001, dm_rdata 0x12F45678, ack on first req cycle -> dm_be 1111, dm_addr 0x1000, mem_valid at cycle 2, memdata 0xFFFFFFF4.
- Unsigned half load, addr 0x2002, dm_rdata 0xAAAA8001 -> memdata 0x00008001; the signed version yields 0xFFFF8001.
- Byte store, addr 0x3003, ex_wdata 0x000000AB -> dm_we 1, dm_be 0001, dm_wdata 0xABABABAB; no mem_valid; stall released on ack.
- Word load at 0x4002 -> misalign_exc pulse; dm_req never asserts; memdata keeps its previous value.
- dm_ack delayed 5 cycles -> dm_req and dm_addr stable for all 5 cycles; stall high throughout. A rst_n=0 pulse during the wait -> dm_req 0 next cycle; a later ack is ignored.
- With MEM_TIMEOUT_EN and no ack -> bus_err pulses after 16 REQ cycles; returns to IDLE; no mem_valid.
